// File: rtl/lpif_tx_buffer_if.sv
// Link-layer beat channel and LPIF TX presentation channel of the transmit
// staging buffer, bundled so both sides of the buffer travel as one port.
interface lpif_tx_buffer_if #(
    parameter int DW = 512,
    parameter int BW = 64
);
    // Upstream (link layer -> buffer)
    logic          ll_valid;
    logic          ll_ready;
    logic [DW-1:0] ll_data;
    logic [BW-1:0] ll_valid_bytes;
    logic [BW-1:0] ll_tlpstart;
    logic [BW-1:0] ll_tlpend;
    logic [BW-1:0] ll_dlpstart;
    logic [BW-1:0] ll_dlpend;

    // Downstream (buffer -> physical layer)
    logic          pl_trdy;
    logic          lp_irdy;
    logic [DW-1:0] lp_data;
    logic [BW-1:0] lp_valid;
    logic [BW-1:0] lp_tlpstart;
    logic [BW-1:0] lp_tlpend;
    logic [BW-1:0] lp_dlpstart;
    logic [BW-1:0] lp_dlpend;

    // Driver side: link layer pushing beats and PHY accepting them
    modport master (
        output ll_valid, ll_data, ll_valid_bytes,
               ll_tlpstart, ll_tlpend, ll_dlpstart, ll_dlpend, pl_trdy,
        input  ll_ready, lp_irdy, lp_data, lp_valid,
               lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend
    );

    // Buffer side
    modport slave (
        input  ll_valid, ll_data, ll_valid_bytes,
               ll_tlpstart, ll_tlpend, ll_dlpstart, ll_dlpend, pl_trdy,
        output ll_ready, lp_irdy, lp_data, lp_valid,
               lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend
    );
endinterface

// File: rtl/lpif_tx_buffer.sv
// Transmit-side staging FIFO between the link layer and the LPIF TX port.
// Beats are accepted while the link is up, presented to the PHY only in
// Active, and any buffered traffic is discarded (and counted) on forced
// detect or link loss.
module lpif_tx_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 512,
    parameter int BW    = 64
) (
    input  logic                     LCLK,
    input  logic                     lpreset,
    lpif_tx_buffer_if.slave          bus,
    input  logic                     pl_linkUp,
    input  logic [3:0]               pl_state_sts,
    input  logic                     lp_force_detect,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               flush_cnt
);
    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] STS_ACTIVE = 4'h1;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        STALL = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] valid_bytes;
        logic [BW-1:0] tlpstart;
        logic [BW-1:0] tlpend;
        logic [BW-1:0] dlpstart;
        logic [BW-1:0] dlpend;
    } entry_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [7:0]    flush_cnt_q, flush_cnt_d;
    entry_t        mem_q [DEPTH];

    entry_t        wr_entry;
    entry_t        head;
    logic          link_ok;
    logic          ll_ready;
    logic          lp_irdy;
    logic          push;
    logic          pop;
    logic [8:0]    flush_sum;

    assign link_ok  = pl_linkUp && !lp_force_detect;
    assign head     = mem_q[rd_ptr_q];
    assign push     = bus.ll_valid && ll_ready;
    assign pop      = lp_irdy && bus.pl_trdy;
    assign wr_entry = '{data:        bus.ll_data,
                        valid_bytes: bus.ll_valid_bytes,
                        tlpstart:    bus.ll_tlpstart,
                        tlpend:      bus.ll_tlpend,
                        dlpstart:    bus.ll_dlpstart,
                        dlpend:      bus.ll_dlpend};

    // Link-state register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge LCLK or negedge lpreset) begin
        if (!lpreset) state_q <= DOWN;
        else          state_q <= state_d;
    end

    // Link-state transitions, decided from this cycle's PHY status
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            DOWN: begin
                if (link_ok) state_d = (pl_state_sts == STS_ACTIVE) ? RUN : STALL;
            end
            RUN, STALL: begin
                if (lp_force_detect || !pl_linkUp)  state_d = FLUSH;
                else if (pl_state_sts == STS_ACTIVE) state_d = RUN;
                else                                 state_d = STALL;
            end
            FLUSH:   state_d = DOWN;
            default: state_d = DOWN;
        endcase
    end

    // Handshake and framing outputs; framing is gated to zero when no beat is offered
    always_comb begin
        ll_ready        = ((state_q == RUN) || (state_q == STALL)) && !occ_q[AW];
        lp_irdy         = (state_q == RUN) && (occ_q != '0);
        bus.ll_ready    = ll_ready;
        bus.lp_irdy     = lp_irdy;
        bus.lp_data     = (occ_q != '0) ? head.data : '0;
        bus.lp_valid    = lp_irdy ? head.valid_bytes : '0;
        bus.lp_tlpstart = lp_irdy ? head.tlpstart    : '0;
        bus.lp_tlpend   = lp_irdy ? head.tlpend      : '0;
        bus.lp_dlpstart = lp_irdy ? head.dlpstart    : '0;
        bus.lp_dlpend   = lp_irdy ? head.dlpend      : '0;
    end

    // Pointer, occupancy and flush-counter next state
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        flush_cnt_d = flush_cnt_q;
        flush_sum   = {1'b0, flush_cnt_q} + 9'(occ_q);
        if (state_q == FLUSH) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            flush_cnt_d = flush_sum[8] ? 8'hFF : flush_sum[7:0];
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pointer, occupancy and flush-counter registers
    always_ff @(posedge LCLK or negedge lpreset) begin
        if (!lpreset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            flush_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Beat storage
    // NOTE: storage has no reset; occupancy gates every read, so stale
    // contents are never observed and the array stays plain RAM.
    always_ff @(posedge LCLK) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign occupancy = occ_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_lpif_tx_buffer.sv
// Self-checking bench for lpif_tx_buffer: directed scenarios with random beat
// contents plus a random-traffic phase, all compared each cycle against a
// queue-based reference model of the buffer.
module tb_lpif_tx_buffer;
    localparam int DEPTH = 4;
    localparam int DW    = 512;
    localparam int BW    = 64;
    localparam int OW    = $clog2(DEPTH) + 1;

    localparam int M_DOWN  = 0;
    localparam int M_STALL = 1;
    localparam int M_RUN   = 2;
    localparam int M_FLUSH = 3;

    typedef struct {
        logic [DW-1:0] d;
        logic [BW-1:0] v;
        logic [BW-1:0] ts;
        logic [BW-1:0] te;
        logic [BW-1:0] ds;
        logic [BW-1:0] de;
    } beat_t;

    logic          LCLK = 1'b0;
    logic          lpreset = 1'b0;
    logic          pl_linkUp = 1'b0;
    logic [3:0]    pl_state_sts = 4'h0;
    logic          lp_force_detect = 1'b0;
    logic [OW-1:0] occupancy;
    logic [7:0]    flush_cnt;

    lpif_tx_buffer_if #(.DW(DW), .BW(BW)) bus ();

    lpif_tx_buffer #(.DEPTH(DEPTH), .DW(DW), .BW(BW)) dut (
        .LCLK            (LCLK),
        .lpreset         (lpreset),
        .bus             (bus),
        .pl_linkUp       (pl_linkUp),
        .pl_state_sts    (pl_state_sts),
        .lp_force_detect (lp_force_detect),
        .occupancy       (occupancy),
        .flush_cnt       (flush_cnt)
    );

    always #5 LCLK = ~LCLK;

    int    total = 0;
    int    bad   = 0;
    int    mode;
    int    fcnt;
    beat_t q[$];

    function automatic beat_t rand_beat(bit dlp_only);
        beat_t b;
        for (int i = 0; i < DW; i += 32) b.d[i +: 32] = $urandom;
        for (int i = 0; i < BW; i += 32) begin
            b.v[i +: 32]  = $urandom;
            b.ts[i +: 32] = dlp_only ? 32'h0 : $urandom;
            b.te[i +: 32] = dlp_only ? 32'h0 : $urandom;
            b.ds[i +: 32] = $urandom;
            b.de[i +: 32] = $urandom;
        end
        return b;
    endfunction

    task automatic drive(input beat_t b, input bit valid);
        bus.ll_valid       = valid;
        bus.ll_data        = b.d;
        bus.ll_valid_bytes = b.v;
        bus.ll_tlpstart    = b.ts;
        bus.ll_tlpend      = b.te;
        bus.ll_dlpstart    = b.ds;
        bus.ll_dlpend      = b.de;
    endtask

    task automatic idle();
        beat_t z;
        z = '{default: '0};
        drive(z, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec-level link mode rules
    function automatic int next_mode(int m, bit up, logic [3:0] sts, bit fd);
        bit active;
        active = (sts == 4'h1);
        if (m == M_FLUSH) return M_DOWN;
        if (m == M_DOWN) begin
            if (!up || fd) return M_DOWN;
            return active ? M_RUN : M_STALL;
        end
        if (fd || !up) return M_FLUSH;
        return active ? M_RUN : M_STALL;
    endfunction

    task automatic model_reset();
        mode = M_DOWN;
        fcnt = 0;
        q.delete();
    endtask

    task automatic check_outputs();
        beat_t h;
        bit    rdy, irdy;
        h    = '{default: '0};
        if (q.size() > 0) h = q[0];
        rdy  = (mode == M_RUN || mode == M_STALL) && (q.size() < DEPTH);
        irdy = (mode == M_RUN) && (q.size() > 0);
        chk("ll_ready",    bus.ll_ready,    rdy);
        chk("lp_irdy",     bus.lp_irdy,     irdy);
        chk("lp_data",     bus.lp_data,     h.d);
        chk("lp_valid",    bus.lp_valid,    irdy ? h.v  : '0);
        chk("lp_tlpstart", bus.lp_tlpstart, irdy ? h.ts : '0);
        chk("lp_tlpend",   bus.lp_tlpend,   irdy ? h.te : '0);
        chk("lp_dlpstart", bus.lp_dlpstart, irdy ? h.ds : '0);
        chk("lp_dlpend",   bus.lp_dlpend,   irdy ? h.de : '0);
        chk("occupancy",   occupancy,       q.size());
        chk("flush_cnt",   flush_cnt,       fcnt);
    endtask

    // Called just after a falling edge with inputs settled: check, advance
    // the model across the rising edge, return at the next falling edge.
    task automatic cycle();
        beat_t in_b;
        bit    push, pop;
        int    nm;
        check_outputs();
        in_b.d  = bus.ll_data;
        in_b.v  = bus.ll_valid_bytes;
        in_b.ts = bus.ll_tlpstart;
        in_b.te = bus.ll_tlpend;
        in_b.ds = bus.ll_dlpstart;
        in_b.de = bus.ll_dlpend;
        push = bus.ll_valid && (mode == M_RUN || mode == M_STALL) && (q.size() < DEPTH);
        pop  = bus.pl_trdy && (mode == M_RUN) && (q.size() > 0);
        nm   = next_mode(mode, pl_linkUp, pl_state_sts, lp_force_detect);
        @(posedge LCLK);
        if (mode == M_FLUSH) begin
            fcnt = (fcnt + q.size() > 255) ? 255 : fcnt + q.size();
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(in_b);
        end
        mode = nm;
        @(negedge LCLK);
    endtask

    task automatic push_beats(input int n, input bit dlp_only);
        for (int i = 0; i < n; i++) begin
            drive(rand_beat(dlp_only), 1'b1);
            cycle();
        end
        idle();
    endtask

    initial begin
        idle();
        bus.pl_trdy = 1'b0;
        model_reset();
        #12 lpreset = 1'b1;
        @(negedge LCLK);

        // Reset state, link still down
        cycle();
        cycle();

        // Link up and Active; three DLLP beats streamed through with pl_trdy=1
        pl_linkUp    = 1'b1;
        pl_state_sts = 4'h1;
        cycle();
        bus.pl_trdy = 1'b1;
        push_beats(3, 1'b1);
        cycle();
        cycle();

        // Back-pressure: offer six beats, only DEPTH accepted
        bus.pl_trdy = 1'b0;
        push_beats(6, 1'b0);
        // Push and pop while full: pop only
        bus.pl_trdy = 1'b1;
        drive(rand_beat(1'b0), 1'b1);
        cycle();
        idle();
        for (int i = 0; i < 4; i++) cycle();

        // Stall: fill 3, leave Active, top up to 4, return and drain
        bus.pl_trdy = 1'b0;
        push_beats(3, 1'b0);
        pl_state_sts = 4'h3;
        cycle();
        bus.pl_trdy = 1'b1;
        push_beats(3, 1'b0);
        cycle();
        pl_state_sts = 4'h1;
        for (int i = 0; i < 6; i++) cycle();

        // Forced detect with 3 held beats, then link down until requalified
        bus.pl_trdy = 1'b0;
        push_beats(3, 1'b0);
        lp_force_detect = 1'b1;
        cycle();
        lp_force_detect = 1'b0;
        pl_linkUp       = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        pl_linkUp = 1'b1;
        cycle();
        cycle();

        // Pop coinciding with forced detect completes, flush takes the rest
        push_beats(3, 1'b0);
        bus.pl_trdy     = 1'b1;
        lp_force_detect = 1'b1;
        cycle();
        lp_force_detect = 1'b0;
        bus.pl_trdy     = 1'b0;
        cycle();
        cycle();

        // Repeated full flushes drive flush_cnt into saturation
        for (int k = 0; k < 70; k++) begin
            cycle();
            push_beats(4, 1'b0);
            lp_force_detect = 1'b1;
            cycle();
            lp_force_detect = 1'b0;
            cycle();
        end
        cycle();

        // Asynchronous reset in the middle of a drain
        push_beats(3, 1'b0);
        bus.pl_trdy = 1'b1;
        cycle();
        #2 lpreset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge LCLK);
        lpreset = 1'b1;
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            pl_linkUp       = ($urandom_range(0, 24) != 0);
            pl_state_sts    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h1;
            lp_force_detect = ($urandom_range(0, 39) == 0);
            bus.pl_trdy     = $urandom_range(0, 1) == 1;
            drive(rand_beat(1'b0), $urandom_range(0, 2) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
